// File: rtl/rw_burst_ctrl.sv
// Burst read/write/loopback sequencer between a serial link and a sync memory.
// Every output is a register loaded from the state the FSM is about to enter.
module rw_burst_ctrl #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int MAX_BURST  = 16,
  parameter int LEN_W      = 5,
  parameter int TX_TIMEOUT = 255
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Active,
  input  logic              Mode,
  input  logic              ValidCmd,
  input  logic              RW,
  input  logic [ADDR_W-1:0] CmdAddr,
  input  logic [LEN_W-1:0]  CmdLen,
  input  logic              RxValid,
  input  logic [DATA_W-1:0] RxData,
  input  logic              TxDone,
  input  logic [DATA_W-1:0] MemRdData,
  output logic              AccessMem,
  output logic              RWMem,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWrData,
  output logic              SampleData,
  output logic              TxData,
  output logic [DATA_W-1:0] TxByte,
  output logic              Busy,
  output logic              Done,
  output logic              Err
);

  // state      | meaning
  // S_IDLE     | waiting for a command
  // S_RD_ISSUE | memory read strobe for the current address
  // S_RD_CAP   | read data returning, handed to the transmitter next
  // S_TX_WAIT  | word in flight, waiting for TxDone under the timeout
  // S_WR_WAIT  | waiting for a received word to store
  // S_WR_DO    | memory write strobe
  // S_LB_WAIT  | waiting for a received word to echo
  // S_DONE     | one-cycle completion report
  typedef enum logic [2:0] {
    S_IDLE, S_RD_ISSUE, S_RD_CAP, S_TX_WAIT, S_WR_WAIT, S_WR_DO, S_LB_WAIT, S_DONE
  } state_t;

  localparam int TMR_W = $clog2(TX_TIMEOUT + 1);

  state_t             state, state_n;
  logic [ADDR_W-1:0]  addr, addr_n;
  logic [LEN_W-1:0]   rem, rem_n, rem_dec;
  logic               mode_q, mode_n;
  logic [TMR_W-1:0]   timer, timer_n;
  logic               busy_state, last_word;
  logic               err_n, access_n, rwmem_n, sample_n, tx_data_n, busy_n, done_n;
  logic [ADDR_W-1:0]  mem_addr_n;
  logic [DATA_W-1:0]  wr_data_n, tx_byte_n;

  assign busy_state = (state != S_IDLE) && (state != S_DONE);
  assign rem_dec    = (rem != '0) ? rem - 1'b1 : rem;
  assign last_word  = (rem <= LEN_W'(1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      addr       <= '0;
      rem        <= '0;
      mode_q     <= 1'b0;
      timer      <= '0;
      AccessMem  <= 1'b0;
      RWMem      <= 1'b0;
      MemAddr    <= '0;
      MemWrData  <= '0;
      SampleData <= 1'b0;
      TxData     <= 1'b0;
      TxByte     <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Err        <= 1'b0;
    end else begin
      state      <= state_n;
      addr       <= addr_n;
      rem        <= rem_n;
      mode_q     <= mode_n;
      timer      <= timer_n;
      AccessMem  <= access_n;
      RWMem      <= rwmem_n;
      MemAddr    <= mem_addr_n;
      MemWrData  <= wr_data_n;
      SampleData <= sample_n;
      TxData     <= tx_data_n;
      TxByte     <= tx_byte_n;
      Busy       <= busy_n;
      Done       <= done_n;
      Err        <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = addr;
    rem_n   = rem;
    mode_n  = mode_q;
    timer_n = timer;
    err_n   = 1'b0;
    case (state)
      S_IDLE: if (ValidCmd && Active) begin
        addr_n = CmdAddr;
        rem_n  = CmdLen;
        mode_n = Mode;
        if (CmdLen == '0 || CmdLen > LEN_W'(MAX_BURST)) err_n = 1'b1;
        else if (!Mode)                                  state_n = S_LB_WAIT;
        else if (RW)                                     state_n = S_RD_ISSUE;
        else                                             state_n = S_WR_WAIT;
      end
      S_RD_ISSUE: state_n = S_RD_CAP;
      S_RD_CAP:   state_n = S_TX_WAIT;
      // TxDone in the last timer cycle still wins over the timeout.
      S_TX_WAIT: if (TxDone) begin
        rem_n = rem_dec;
        if (mode_q) addr_n = addr + 1'b1;
        if (last_word)   state_n = S_DONE;
        else if (mode_q) state_n = S_RD_ISSUE;
        else             state_n = S_LB_WAIT;
      end else if (timer == '0) begin
        err_n   = 1'b1;
        state_n = S_IDLE;
      end
      S_WR_WAIT: if (RxValid) state_n = S_WR_DO;
      S_WR_DO: begin
        addr_n  = addr + 1'b1;
        rem_n   = rem_dec;
        state_n = last_word ? S_DONE : S_WR_WAIT;
      end
      S_LB_WAIT: if (RxValid) state_n = S_TX_WAIT;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
    if (busy_state && !Active) begin
      state_n = S_IDLE;
      addr_n  = addr;
      rem_n   = rem;
      err_n   = 1'b1;
    end
    if (state_n == S_TX_WAIT && state != S_TX_WAIT) timer_n = TMR_W'(TX_TIMEOUT - 1);
    else if (state == S_TX_WAIT && timer != '0)     timer_n = timer - 1'b1;
  end

  always_comb begin
    access_n   = 1'b0;
    rwmem_n    = 1'b0;
    mem_addr_n = MemAddr;
    wr_data_n  = MemWrData;
    sample_n   = 1'b0;
    tx_data_n  = 1'b0;
    tx_byte_n  = TxByte;
    done_n     = 1'b0;
    busy_n     = (state_n != S_IDLE) && (state_n != S_DONE);
    case (state_n)
      S_RD_ISSUE: begin
        access_n   = 1'b1;
        mem_addr_n = addr_n;
      end
      S_WR_DO: begin
        access_n   = 1'b1;
        rwmem_n    = 1'b1;
        mem_addr_n = addr_n;
        wr_data_n  = RxData;
      end
      S_WR_WAIT, S_LB_WAIT: sample_n = 1'b1;
      S_DONE:               done_n   = 1'b1;
      default: ;
    endcase
    if (state_n == S_TX_WAIT && state != S_TX_WAIT) begin
      tx_data_n = 1'b1;
      tx_byte_n = (state == S_RD_CAP) ? MemRdData : RxData;
    end
  end

endmodule

// File: tb/tb_rw_burst_ctrl.sv
// Scoreboard bench for rw_burst_ctrl: directed bursts push expected accesses,
// transmitted words and Done/Err events; a negedge monitor pops and compares.
module tb_rw_burst_ctrl;
  localparam int DW = 8, AW = 8, MB = 16, LW = 5, TO = 20;

  logic          Clk = 1'b0, Reset = 1'b1, Active = 1'b0, Mode = 1'b0, ValidCmd = 1'b0, RW = 1'b0;
  logic [AW-1:0] CmdAddr = '0;
  logic [LW-1:0] CmdLen = '0;
  logic          RxValid = 1'b0, TxDone = 1'b0;
  logic [DW-1:0] RxData = '0;
  logic [DW-1:0] MemRdData = '0;
  logic          AccessMem, RWMem, SampleData, TxData, Busy, Done, Err;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWrData, TxByte;

  rw_burst_ctrl #(.DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB), .LEN_W(LW), .TX_TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .Active(Active), .Mode(Mode), .ValidCmd(ValidCmd), .RW(RW),
    .CmdAddr(CmdAddr), .CmdLen(CmdLen), .RxValid(RxValid), .RxData(RxData), .TxDone(TxDone),
    .MemRdData(MemRdData), .AccessMem(AccessMem), .RWMem(RWMem), .MemAddr(MemAddr),
    .MemWrData(MemWrData), .SampleData(SampleData), .TxData(TxData), .TxByte(TxByte),
    .Busy(Busy), .Done(Done), .Err(Err));

  always #5 Clk = ~Clk;

  // synchronous memory model with a bench-side preload port
  logic [7:0] mem [256];
  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = '0, pre_data = '0;
  always @(posedge Clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (AccessMem && RWMem) mem[MemAddr] <= MemWrData;
    if (AccessMem && !RWMem) MemRdData <= mem[MemAddr];
  end

  typedef struct packed { logic w; logic [7:0] a; logic [7:0] d; } acc_t;
  acc_t       exp_acc[$];
  logic [7:0] exp_tx[$];
  logic [1:0] exp_evt[$];   // {Done, Err}

  int n_cmp = 0, n_err = 0;
  int cyc = 0, tx_cyc = 0, err_cyc = 0, busy_cnt = 0;
  int tx_delay = 4;

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: unexpected event (cycle %0d)", nm, cyc);
  endfunction

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (!Reset) begin
      acc_t e;
      if (Busy) busy_cnt++;
      if (AccessMem) begin
        if (exp_acc.size() == 0) fail_now("mem_access");
        else begin
          e = exp_acc.pop_front();
          chk("acc_we", RWMem, e.w);
          chk("acc_addr", MemAddr, e.a);
          if (e.w) chk("acc_wdata", MemWrData, e.d);
        end
      end else if (RWMem) fail_now("rwmem_without_access");
      if (TxData) begin
        tx_cyc = cyc;
        if (exp_tx.size() == 0) fail_now("tx_pulse");
        else chk("tx_byte", TxByte, exp_tx.pop_front());
      end
      if (Done || Err) begin
        if (exp_evt.size() == 0) fail_now("done_err");
        else chk("evt_done_err", {Done, Err}, exp_evt.pop_front());
        if (Done) chk("busy_at_done", Busy, 0);
        if (Err) begin
          err_cyc = cyc;
          chk("busy_at_err", Busy, 0);
        end
      end
    end
  end

  // transmitter: answers each TxData with TxDone tx_delay cycles later (never if negative)
  initial forever begin
    @(negedge Clk);
    if (TxData && tx_delay >= 0) begin
      repeat (tx_delay) @(negedge Clk);
      TxDone = 1'b1;
      @(negedge Clk);
      TxDone = 1'b0;
    end
  end

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge Clk); pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge Clk); pre_we = 1'b0;
  endtask

  task automatic cmd(input logic m, input logic r, input logic [7:0] a, input logic [4:0] l);
    @(negedge Clk); Mode = m; RW = r; CmdAddr = a; CmdLen = l; ValidCmd = 1'b1;
    @(negedge Clk); ValidCmd = 1'b0;
  endtask

  task automatic wait_sample();
    int n = 0;
    while (!SampleData && n < 200) begin @(negedge Clk); n++; end
    if (!SampleData) fail_now("sample_wait_timeout");
  endtask

  task automatic rx(input logic [7:0] d);
    wait_sample();
    if (SampleData) begin
      RxValid = 1'b1; RxData = d;
      @(negedge Clk); RxValid = 1'b0;
    end
  endtask

  task automatic settle();
    int n = 0, idle = 0;
    while (idle < 3 && n < 300) begin
      @(negedge Clk); n++;
      idle = Busy ? 0 : idle + 1;
    end
    if (idle < 3) fail_now("idle_wait_timeout");
    chk("acc_queue_drained", exp_acc.size(), 0);
    chk("tx_queue_drained", exp_tx.size(), 0);
    chk("evt_queue_drained", exp_evt.size(), 0);
  endtask

  function automatic logic [39:0] outs();
    return {AccessMem, RWMem, MemAddr, MemWrData, SampleData, TxData, TxByte, Busy, Done, Err};
  endfunction

  initial begin
    int b0;
    repeat (3) @(negedge Clk);
    chk("reset_outputs", int'(outs() != 0), 0);
    Reset = 1'b0; Active = 1'b1;
    preload(8'hFE, 8'h11); preload(8'hFF, 8'h22); preload(8'h00, 8'h33);
    preload(8'h40, 8'h5E); preload(8'h41, 8'h9D);

    // read burst wrapping the address space
    tx_delay = 4;
    exp_acc.push_back('{1'b0, 8'hFE, 8'h00}); exp_acc.push_back('{1'b0, 8'hFF, 8'h00});
    exp_acc.push_back('{1'b0, 8'h00, 8'h00});
    exp_tx.push_back(8'h11); exp_tx.push_back(8'h22); exp_tx.push_back(8'h33);
    exp_evt.push_back(2'b10);
    cmd(1'b1, 1'b1, 8'hFE, 5'd3);
    settle();

    // write burst
    exp_acc.push_back('{1'b1, 8'h10, 8'hA5}); exp_acc.push_back('{1'b1, 8'h11, 8'h5A});
    exp_evt.push_back(2'b10);
    cmd(1'b1, 1'b0, 8'h10, 5'd2);
    rx(8'hA5); rx(8'h5A);
    settle();
    chk("mem_10", mem[8'h10], 8'hA5);
    chk("mem_11", mem[8'h11], 8'h5A);

    // loopback, with a stray command strobe while busy
    tx_delay = 2;
    exp_tx.push_back(8'h3C); exp_tx.push_back(8'hC3);
    exp_evt.push_back(2'b10);
    cmd(1'b0, 1'b1, 8'h00, 5'd2);
    cmd(1'b1, 1'b1, 8'h40, 5'd1);
    rx(8'h3C); rx(8'hC3);
    settle();

    // illegal lengths
    b0 = busy_cnt;
    exp_evt.push_back(2'b01); exp_evt.push_back(2'b01);
    cmd(1'b1, 1'b1, 8'h20, 5'd0);
    cmd(1'b1, 1'b1, 8'h20, 5'd17);
    settle();
    chk("bad_cmd_busy_cycles", busy_cnt - b0, 0);

    // TxDone withheld: timeout
    tx_delay = -1;
    exp_acc.push_back('{1'b0, 8'h40, 8'h00}); exp_tx.push_back(8'h5E); exp_evt.push_back(2'b01);
    cmd(1'b1, 1'b1, 8'h40, 5'd1);
    settle();
    chk("timeout_latency", err_cyc - tx_cyc, TO);

    // TxDone in the final timer cycle still completes
    tx_delay = TO - 1;
    exp_acc.push_back('{1'b0, 8'h41, 8'h00}); exp_tx.push_back(8'h9D); exp_evt.push_back(2'b10);
    cmd(1'b1, 1'b1, 8'h41, 5'd1);
    settle();
    tx_delay = 4;

    // maximum-length write wrapping the address space
    for (int i = 0; i < MB; i++) exp_acc.push_back('{1'b1, 8'(8'hF8 + i), 8'(i * 7 + 3)});
    exp_evt.push_back(2'b10);
    cmd(1'b1, 1'b0, 8'hF8, 5'(MB));
    for (int i = 0; i < MB; i++) rx(8'(i * 7 + 3));
    settle();
    chk("mem_07", mem[8'h07], 8'(15 * 7 + 3));

    // Active dropped mid write burst
    exp_acc.push_back('{1'b1, 8'h80, 8'h77}); exp_evt.push_back(2'b01);
    cmd(1'b1, 1'b0, 8'h80, 5'd4);
    rx(8'h77);
    wait_sample();
    Active = 1'b0;
    @(negedge Clk);
    chk("abort_busy", Busy, 0);
    chk("abort_err", Err, 1);
    Active = 1'b1;
    settle();

    // Reset mid write burst
    exp_acc.push_back('{1'b1, 8'h90, 8'h66});
    cmd(1'b1, 1'b0, 8'h90, 5'd4);
    rx(8'h66);
    wait_sample();
    Reset = 1'b1;
    @(negedge Clk);
    chk("reset_mid_burst_outputs", int'(outs() != 0), 0);
    Reset = 1'b0;
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
